fetch_decode_stage: RTL and testbench
=====================================

# fetch_decode_stage

Instruction fetch and IF/ID pipeline register feeding the immediate generator. Holds the PC, issues one-at-a-time requests to instruction memory with a req/ack handshake, and latches the returned word. It presents the instruction and PC, plus the 12-bit immediate field packed per instruction format, which the immediate generator sign-extends to 32 bits. It also handles branch redirects and downstream stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request, held high until imem_ack
- imem_addr  output  32  fetch address, stable while imem_req high
- imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction word
- branch_taken  input  1  one-cycle redirect pulse
- branch_target  input  32  redirect address, sampled with branch_taken
- id_ready  input  1  consumer accepts the IF/ID entry this cycle
- id_valid  output  1  IF/ID entry valid
- id_instr  output  32  latched instruction
- id_pc  output  32  address of id_instr
- id_imm12  output  12  packed immediate field, to the immediate generator
- id_imm_type  output  2  0=none, 1=I, 2=S, 3=B
- misalign_err  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- The block has three states:
  - FETCH: request outstanding.
  - FULL: IF/ID entry valid, waiting for the consumer.
  - DISCARD: request outstanding whose data must be dropped.
- Registers:
  - pc: next fetch address.
  - req_addr: address of the current request; drives imem_addr.
  - IF/ID fields.
- imem_req = (state==FETCH or DISCARD). imem_addr = req_addr. Memory acks each request exactly once. Ack may arrive in the first cycle of the request or in any later cycle.
- FETCH:
  - On ack: latch id_instr=imem_rdata, id_pc=req_addr, id_valid=1; set pc=req_addr+4; go to FULL.
  - Without ack: hold.
- FULL:
  - id_ready=1: id_valid clears next cycle; req_addr=pc; go to FETCH.
  - id_ready=0: all id_* outputs hold unchanged.
- DISCARD:
  - On ack: drop the data; req_addr=pc; go to FETCH.
- Redirect (branch_taken=1) overrides id_ready:
  - FETCH without ack: pc=target; go to DISCARD. req_addr is unchanged, so the request stays stable.
  - FETCH with ack in the same cycle: drop the data; req_addr=pc=target; stay in FETCH.
  - FULL: id_valid=0; req_addr=pc=target; go to FETCH.
  - DISCARD: pc=target; stay in DISCARD. The latest target wins.
- Immediate packing is decoded from imem_rdata[6:0] at latch time:
  - I-type (0010011, 0000011, 1100111): id_imm12 = instr[31:20], type 1.
  - S-type (0100011): id_imm12 = {instr[31:25], instr[11:7]}, type 2.
  - B-type (1100011): id_imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]}, type 3. This field is offset[12:1]; the consumer shifts it left by 1.
  - Any other opcode: id_imm12 = 0, type 0.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=FETCH; pc=req_addr=RESET_PC.
  - id_valid=0; id_instr=0; id_pc=0; id_imm12=0; id_imm_type=0; misalign_err=0.
  - imem_req=1 from the first edge after rst_n rises. While rst_n is low, imem_req is forced to 0.
- Reset mid-request returns to the reset state. Any ack for the aborted request arriving after reset is a memory-side error and is not handled.
- Latency:
  - Ack in cycle N gives id_valid=1 in cycle N+1.
  - id_ready in cycle M gives imem_req=1 with the new address in cycle M+1.
  - Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Redirect takes effect on the next edge. No instruction from the old path ever reaches id_valid=1 after branch_taken.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with branch_target[1:0]!=0 sets misalign_err=1. The flag is sticky until reset.
  - After the flag sets, the block completes or discards any outstanding request, then stays in an idle state with imem_req=0 and id_valid=0.
- FETCH_MISALIGN_TRAP_EN undefined:
  - branch_target[1:0] is forced to 0.
  - misalign_err is tied to 0.

## Test plan
- Reset and sequential fetch, RESET_PC=0, zero-wait ack, id_ready=1 → imem_addr sequence 0,4,8. id_pc matches. id_valid high every other cycle.
- Fetch of 0x00500093 (addi x1,x0,5) → id_imm12=12'h005, type 1. Fetch of 0xFE112E23 (sw x1,-4(x2)) → 12'hFFC, type 2. Fetch of 0xFE0008E3 (beq, offset -16) → 12'hFF8, type 3.
- id_ready=0 for 5 cycles with id_valid=1 → id_* outputs stable and imem_req=0 throughout. Release → next fetch at id_pc+4.
- 3-cycle-latency memory, branch_taken to 0x100 one cycle into the request → old address held until ack and data dropped. Next request to 0x100. No id_valid for the old word.
- branch_taken in the same cycle as ack and id_ready in FULL → redirect wins. The next request and id_pc are at branch_target.
- With FETCH_MISALIGN_TRAP_EN defined, redirect to 0x102 → misalign_err=1 and imem_req stays 0 until rst_n. Without the macro → fetch proceeds from 0x100.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Instruction fetch plus IF/ID pipeline register: req/ack imem handshake, branch redirect,
// downstream stall and 12-bit immediate packing. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [11:0] id_imm12_o,
    output logic [1:0]  id_imm_type_o,
    output logic        misalign_err_o
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_IDLE    = 2'd3
    } state_e;

    // Returns {imm_type, imm12}; B-type carries offset[12:1].
    function automatic logic [13:0] pack_imm(input logic [31:0] instr);
        logic [13:0] r;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: r = {2'd1, instr[31:20]};
            7'b0100011: r = {2'd2, instr[31:25], instr[11:7]};
            7'b1100011: r = {2'd3, instr[31], instr[7], instr[30:25], instr[11:8]};
            default:    r = 14'd0;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [11:0] id_imm12_q, id_imm12_d;
    logic [1:0]  id_imm_type_q, id_imm_type_d;
    logic        err_q, err_d;
    logic        started_q;

    logic [31:0] target_s;
    logic        trap_hit_s;
    logic        ack_s;
    logic [13:0] imm_pack_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_s       = branch_target_i;
    assign trap_hit_s     = branch_taken_i & (|branch_target_i[1:0]);
    assign misalign_err_o = err_q;
`else
    assign target_s       = branch_target_i & 32'hFFFF_FFFC;
    assign trap_hit_s     = 1'b0;
    assign misalign_err_o = 1'b0;
`endif

    // Acks are only meaningful once the request line has come out of reset.
    assign ack_s       = imem_ack_i & started_q;
    assign imm_pack_s  = pack_imm(imem_rdata_i);

    assign imem_req_o    = started_q & ((state_q == ST_FETCH) | (state_q == ST_DISCARD));
    assign imem_addr_o   = req_addr_q;
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_pc_o       = id_pc_q;
    assign id_imm12_o    = id_imm12_q;
    assign id_imm_type_o = id_imm_type_q;

    // Next-state logic; a redirect always beats id_ready and any same-cycle ack.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_imm12_d    = id_imm12_q;
        id_imm_type_d = id_imm_type_q;
        err_d         = err_q | trap_hit_s;
        case (state_q)
            ST_FETCH: begin
                if (branch_taken_i) begin
                    if (ack_s) begin
                        req_addr_d = target_s;
                        pc_d       = target_s;
                        state_d    = err_d ? ST_IDLE : ST_FETCH;
                    end else begin
                        // Keep the in-flight address stable; its data gets dropped.
                        pc_d    = target_s;
                        state_d = ST_DISCARD;
                    end
                end else if (ack_s) begin
                    id_valid_d    = 1'b1;
                    id_instr_d    = imem_rdata_i;
                    id_pc_d       = req_addr_q;
                    id_imm_type_d = imm_pack_s[13:12];
                    id_imm12_d    = imm_pack_s[11:0];
                    pc_d          = req_addr_q + 32'd4;
                    state_d       = ST_FULL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FULL: begin
                if (branch_taken_i) begin
                    id_valid_d = 1'b0;
                    req_addr_d = target_s;
                    pc_d       = target_s;
                    state_d    = err_d ? ST_IDLE : ST_FETCH;
                end else if (id_ready_i) begin
                    id_valid_d = 1'b0;
                    req_addr_d = pc_q;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_DISCARD: begin
                if (ack_s) begin
                    if (branch_taken_i) begin
                        req_addr_d = target_s;
                        pc_d       = target_s;
                    end else begin
                        req_addr_d = pc_q;
                    end
                    state_d = err_d ? ST_IDLE : ST_FETCH;
                end else if (branch_taken_i) begin
                    pc_d = target_s;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            ST_IDLE: begin
                id_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and IF/ID registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_imm12_q    <= 12'd0;
            id_imm_type_q <= 2'd0;
            err_q         <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_imm12_q    <= id_imm12_d;
            id_imm_type_q <= id_imm_type_d;
            err_q         <= err_d;
            started_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: expected IF/ID entries are queued as each
// scenario is set up and popped when a new id_valid entry appears.
module tb_fetch_decode_stage;

    logic        clk, rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready, id_valid;
    logic [31:0] id_instr, id_pc;
    logic [11:0] id_imm12;
    logic [1:0]  id_imm_type;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 0;
    int wcnt     = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem      [logic [31:0]];
    logic [11:0] exp_imm  [logic [31:0]];
    logic [1:0]  exp_type [logic [31:0]];

    fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_rdata_i   (imem_rdata),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .id_ready_i     (id_ready),
        .id_valid_o     (id_valid),
        .id_instr_o     (id_instr),
        .id_pc_o        (id_pc),
        .id_imm12_o     (id_imm12),
        .id_imm_type_o  (id_imm_type),
        .misalign_err_o (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[23:0], 8'h33};
    endfunction

    function automatic logic [11:0] imm_of(input logic [31:0] a);
        if (exp_imm.exists(a)) return exp_imm[a];
        return 12'h000;
    endfunction

    function automatic logic [1:0] type_of(input logic [31:0] a);
        if (exp_type.exists(a)) return exp_type[a];
        return 2'd0;
    endfunction

    // Instruction memory: acks after mem_lat waiting cycles of an asserted request.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req === 1'b1 && rst_n === 1'b1) begin
                if (wcnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wcnt       = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard: every rising id_valid must match the head of the expected queue.
    initial begin
        logic        prev_v;
        logic [31:0] p;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (id_valid === 1'b1 && prev_v !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_entry_pc", id_pc, 32'hDEAD_BEEF);
                end else begin
                    p = exp_q.pop_front();
                    check_eq("id_pc", id_pc, p);
                    check_eq("id_instr", id_instr, mem_word(p));
                    check_eq("id_imm12", {20'd0, id_imm12}, {20'd0, imm_of(p)});
                    check_eq("id_imm_type", {30'd0, id_imm_type}, {30'd0, type_of(p)});
                end
            end
            prev_v = id_valid;
        end
    end

    task automatic do_reset();
        branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        id_ready      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        mem_lat       = 0;

        mem[32'h0000_0000] = 32'h0050_0093; exp_imm[32'h0000_0000] = 12'h005; exp_type[32'h0000_0000] = 2'd1;
        mem[32'h0000_0004] = 32'hFE11_2E23; exp_imm[32'h0000_0004] = 12'hFFC; exp_type[32'h0000_0004] = 2'd2;
        mem[32'h0000_0008] = 32'hFE00_08E3; exp_imm[32'h0000_0008] = 12'hFF8; exp_type[32'h0000_0008] = 2'd3;
        mem[32'h0000_000C] = 32'h00C1_2083; exp_imm[32'h0000_000C] = 12'h00C; exp_type[32'h0000_000C] = 2'd1;
        mem[32'h0000_0010] = 32'h0000_8067; exp_imm[32'h0000_0010] = 12'h000; exp_type[32'h0000_0010] = 2'd1;
        mem[32'h0000_0100] = 32'h0000_0463; exp_imm[32'h0000_0100] = 12'h004; exp_type[32'h0000_0100] = 2'd3;
        mem[32'h0000_0200] = 32'h0053_2423; exp_imm[32'h0000_0200] = 12'h008; exp_type[32'h0000_0200] = 2'd2;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_req", imem_req, 32'd0);
        check_eq("rst_valid", id_valid, 32'd0);
        check_eq("rst_err", misalign_err, 32'd0);
        check_eq("rst_instr", id_instr, 32'd0);
        check_eq("rst_pc", id_pc, 32'd0);
        check_eq("rst_imm", {20'd0, id_imm12}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);

        // Sequential zero-wait fetch, valid every other cycle
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_eq("seq_req_first", imem_req, 32'd1);
                check_eq("seq_addr_first", imem_addr, 32'h0);
            end
            if (k == 3) check_eq("seq_addr_4", imem_addr, 32'h4);
            if (k == 5) check_eq("seq_addr_8", imem_addr, 32'h8);
            check_eq("seq_valid", id_valid, ((k % 2) == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check_eq("seq_addr_c", imem_addr, 32'hC);
        id_ready = 1'b0;

        // Downstream stall holds the entry and the request line low
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check_eq("stall_valid", id_valid, 32'd1);
            check_eq("stall_req", imem_req, 32'd0);
            check_eq("stall_pc", id_pc, 32'hC);
            check_eq("stall_instr", id_instr, 32'h00C1_2083);
            check_eq("stall_imm", {20'd0, id_imm12}, 32'h00C);
        end
        exp_q.push_back(32'h10);
        id_ready = 1'b1;
        @(negedge clk);
        check_eq("release_req", imem_req, 32'd1);
        check_eq("release_addr", imem_addr, 32'h10);
        id_ready = 1'b0;
        wait_drain(20);

        // Redirect one cycle into a 3-cycle-latency request
        mem_lat  = 3;
        id_ready = 1'b0;
        exp_q.push_back(32'h100);
        do_reset();
        @(negedge clk);
        check_eq("disc_addr_start", imem_addr, 32'h0);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        branch_taken = 1'b0;
        check_eq("disc_req_held", imem_req, 32'd1);
        check_eq("disc_addr_held", imem_addr, 32'h0);
        @(negedge clk);
        check_eq("disc_addr_at_ack", imem_addr, 32'h0);
        @(negedge clk);
        check_eq("disc_new_req", imem_req, 32'd1);
        check_eq("disc_new_addr", imem_addr, 32'h100);
        wait_drain(20);

        // Redirect with a same-cycle ack, then redirect in FULL beating id_ready
        mem_lat  = 0;
        id_ready = 1'b0;
        exp_q.push_back(32'h200); exp_q.push_back(32'h300);
        do_reset();
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        @(negedge clk);
        branch_taken = 1'b0;
        check_eq("br_ack_addr", imem_addr, 32'h200);
        @(negedge clk);
        id_ready      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        @(negedge clk);
        branch_taken = 1'b0;
        id_ready     = 1'b0;
        check_eq("br_full_valid", id_valid, 32'd0);
        check_eq("br_full_req", imem_req, 32'd1);
        check_eq("br_full_addr", imem_addr, 32'h300);
        wait_drain(20);

        // PC wraps from the top of the address space
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        do_reset();
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_taken = 1'b0;
        check_eq("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        check_eq("wrap_addr_zero", imem_addr, 32'h0);
        wait_drain(20);

        // Misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
        do_reset();
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        @(negedge clk);
        branch_taken = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check_eq("trap_err", misalign_err, 32'd1);
            check_eq("trap_req", imem_req, 32'd0);
            check_eq("trap_valid", id_valid, 32'd0);
            @(negedge clk);
        end
`else
        exp_q.push_back(32'h100);
        do_reset();
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        @(negedge clk);
        branch_taken = 1'b0;
        check_eq("misal_addr", imem_addr, 32'h100);
        check_eq("misal_req", imem_req, 32'd1);
        check_eq("misal_err", misalign_err, 32'd0);
        wait_drain(20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
